// File: rtl/cordic_stage0_if.sv
// ---------------------------------------------------------------------------
// cordic_stage0_if
//   Bundles the data and valid signals of the CORDIC quadrant pre-rotation
//   stage. The producer drives the master modport and the stage consumes the
//   slave modport.
//
//   valid_in   producer -> stage  Xin/Yin/Zin/theta valid this cycle
//   Xin, Yin   producer -> stage  16-bit signed vector components
//   Zin        producer -> stage  16-bit signed target angle, Q2.14 rad
//   theta      producer -> stage  18-bit signed pi constant, Q3.14
//   valid_out  stage -> consumer  Xout/Yout/Zout valid
//   Xout, Yout stage -> consumer  18-bit signed rotated vector
//   Zout       stage -> consumer  18-bit signed residual angle, Q3.14
// ---------------------------------------------------------------------------
interface cordic_stage0_if;
    logic               valid_in;
    logic signed [15:0] Xin;
    logic signed [15:0] Yin;
    logic signed [15:0] Zin;
    logic signed [17:0] theta;
    logic               valid_out;
    logic signed [17:0] Xout;
    logic signed [17:0] Yout;
    logic signed [17:0] Zout;

    modport master (
        output valid_in, Xin, Yin, Zin, theta,
        input  valid_out, Xout, Yout, Zout
    );

    modport slave (
        input  valid_in, Xin, Yin, Zin, theta,
        output valid_out, Xout, Yout, Zout
    );
endinterface

// File: rtl/cordic_stage0.sv
// ---------------------------------------------------------------------------
// cordic_stage0
//   First stage of the pipelined rotation-mode CORDIC: rotates the input
//   vector by +/-pi/2 depending on the sign of the target angle, so that the
//   residual angle handed to the arctan iterations lies in [-pi/2, +pi/2].
//   One register stage, one result per clock, no backpressure.
//
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset (clears outputs and valid)
//   bus    slave modport of cordic_stage0_if (see interface header)
// ---------------------------------------------------------------------------
module cordic_stage0 (
    input  logic          clk,
    input  logic          rst_n,
    cordic_stage0_if.slave bus
);

    localparam int IN_W  = 16;
    localparam int OUT_W = 18;

    // Full-precision negate; the two guard bits make -(-32768) representable.
    function automatic logic signed [OUT_W-1:0] neg_ext(
        input logic signed [OUT_W-1:0] a
    );
        return -a;
    endfunction

    logic signed [OUT_W-1:0] w_x_ext;
    logic signed [OUT_W-1:0] w_y_ext;
    logic signed [OUT_W-1:0] w_z_ext;
    logic signed [OUT_W-1:0] w_half_pi;
    logic                    w_z_pos;
    logic signed [OUT_W-1:0] w_x_rot;
    logic signed [OUT_W-1:0] w_y_rot;
    logic signed [OUT_W-1:0] w_z_rot;

    logic                    r_vld_p0;
    logic signed [OUT_W-1:0] r_x_p0;
    logic signed [OUT_W-1:0] r_y_p0;
    logic signed [OUT_W-1:0] r_z_p0;

    assign w_x_ext   = {{(OUT_W-IN_W){bus.Xin[IN_W-1]}}, bus.Xin};
    assign w_y_ext   = {{(OUT_W-IN_W){bus.Yin[IN_W-1]}}, bus.Yin};
    assign w_z_ext   = {{(OUT_W-IN_W){bus.Zin[IN_W-1]}}, bus.Zin};
    assign w_half_pi = bus.theta >>> 1;
    // Zero angle takes the positive branch.
    assign w_z_pos   = ~bus.Zin[IN_W-1];

    always_comb begin
        w_x_rot = '0;
        w_y_rot = '0;
        w_z_rot = '0;
        if (w_z_pos) begin
            w_x_rot = neg_ext(w_y_ext);
            w_y_rot = w_x_ext;
            w_z_rot = w_z_ext - w_half_pi;
        end else begin
            w_x_rot = w_y_ext;
            w_y_rot = neg_ext(w_x_ext);
            w_z_rot = w_z_ext + w_half_pi;
        end
    end

    // ---- stage p0: output register ----
    // Datapath loads every cycle; valid only qualifies it downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p0 <= 1'b0;
            r_x_p0   <= '0;
            r_y_p0   <= '0;
            r_z_p0   <= '0;
        end else begin
            r_vld_p0 <= bus.valid_in;
            r_x_p0   <= w_x_rot;
            r_y_p0   <= w_y_rot;
            r_z_p0   <= w_z_rot;
        end
    end

    assign bus.valid_out = r_vld_p0;
    assign bus.Xout      = r_x_p0;
    assign bus.Yout      = r_y_p0;
    assign bus.Zout      = r_z_p0;

endmodule

// File: tb/tb_cordic_stage0.sv
module tb_cordic_stage0;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    cordic_stage0_if bus ();

    cordic_stage0 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int x, input int y, input int z);
        bus.valid_in = v;
        bus.Xin      = 16'(x);
        bus.Yin      = 16'(y);
        bus.Zin      = 16'(z);
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input int x,
                              input int y, input int z);
        check({tag, ".vld"}, 64'(bus.valid_out), 64'(v));
        check({tag, ".X"}, 64'(bus.Xout), 64'(x));
        check({tag, ".Y"}, 64'(bus.Yout), 64'(y));
        check({tag, ".Z"}, 64'(bus.Zout), 64'(z));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.theta = 18'sd51471;
        drive(1'b0, 0, 0, 0);

        // Reset held before any clock edge
        #3;
        expect_out("rst_noclk", 1'b0, 0, 0, 0);

        // Inputs toggling while reset held
        drive(1'b1, 1234, -4321, 777);
        edge_sample();
        drive(1'b1, -999, 555, -3000);
        edge_sample();
        expect_out("rst_hold", 1'b0, 0, 0, 0);

        // Release; next edge loads live data
        rst_n = 1'b1;
        drive(1'b1, 9949, 0, 0);
        edge_sample();
        expect_out("z0", 1'b1, 0, 9949, -25735);

        drive(1'b1, 9949, 0, 25728);
        edge_sample();
        expect_out("z6480", 1'b1, 0, 9949, -7);

        drive(1'b1, 9949, 0, -128);
        edge_sample();
        expect_out("zff80", 1'b1, 0, -9949, 25607);

        drive(1'b1, 9949, 0, -32768);
        edge_sample();
        expect_out("zmin", 1'b1, 0, -9949, -7033);

        drive(1'b1, 0, -32768, 0);
        edge_sample();
        expect_out("ymin", 1'b1, 32768, 0, -25735);

        drive(1'b1, -32768, 0, -1);
        edge_sample();
        expect_out("xmin", 1'b1, 0, 32768, 25734);

        // Datapath updates even with valid_in low
        drive(1'b0, 100, 200, -1);
        edge_sample();
        expect_out("novld", 1'b0, 200, -100, 25734);

        // theta change applies to the next result: half_pi = 20000
        bus.theta = 18'sd40000;
        drive(1'b1, 5, -7, 1000);
        edge_sample();
        expect_out("theta", 1'b1, 7, 5, -19000);
        bus.theta = 18'sd51471;

        // Asynchronous reset mid-cycle clears outputs without a clock edge
        drive(1'b1, 300, 400, 500);
        edge_sample();
        expect_out("pre_arst", 1'b1, -400, 300, -25235);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("arst", 1'b0, 0, 0, 0);
        rst_n = 1'b1;
        drive(1'b1, -20, 30, -40);
        edge_sample();
        expect_out("release", 1'b1, 30, 20, 25695);

        // Sweep Z over {k[8:0], 7'b0}
        for (int k = 0; k < 512; k++) begin
            logic [15:0]        zr;
            logic signed [15:0] zs;
            int                 xi, yi, xe, ye, ze;
            longint             e_in, e_out;
            zr = {k[8:0], 7'b0};
            zs = $signed(zr);
            xi = k * 61 - 15000;
            yi = 9000 - k * 35;
            if (zs >= 0) begin
                xe = -yi; ye = xi; ze = int'(zs) - 25735;
            end else begin
                xe = yi; ye = -xi; ze = int'(zs) + 25735;
            end
            drive(k[0], xi, yi, int'(zs));
            edge_sample();
            check("sweep.vld", 64'(bus.valid_out), 64'(k[0]));
            check("sweep.X", 64'(bus.Xout), 64'(xe));
            check("sweep.Y", 64'(bus.Yout), 64'(ye));
            check("sweep.Z", 64'(bus.Zout), 64'(ze));
            e_in  = longint'(xi) * xi + longint'(yi) * yi;
            e_out = longint'(bus.Xout) * bus.Xout + longint'(bus.Yout) * bus.Yout;
            check("sweep.mag", e_out, e_in);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
